opentitan_soc_top: RTL and testbench
====================================

Name: opentitan_soc_top

Overview:
UART boot-loader front end of the OpenTitan SoC top. It receives a program image serially on uart_rx_inst (8N1, LSB first) and assembles each group of 4 bytes into a little-endian 32-bit word. Each word is written to an internal instruction memory. The internal system reset is released when a sentinel word arrives. Load status is exported on gpio_o, received boot bytes are echoed on uart_tx, and the temperature-sensor clock is passed through.

Parameters:
- JTAG_ID, 32'h0000_0001, identification constant; no functional effect in this block.
- DirectDmiTap, 1'b1, debug tap selection; no functional effect in this block.
- DATA_WIDTH, 32, instruction word width; only 32 is supported.
- CLKS_PER_BIT, 10417, clk_i cycles per UART bit (100 MHz / 9600 baud, rounded up).
- IMEM_DEPTH, 1024, instruction memory depth in words; must be a power of 2.

Ports:
- clk_i  in  1  system clock, 100 MHz.
- rst_ni  in  1  asynchronous active-low reset.
- tempsense_clkref  in  1  temperature-sensor reference clock.
- tempsense_clkout  out  1  temperature-sensor clock output.
- sel  in  1  1 = UART boot-load mode; 0 = bypass mode.
- spi_ss  out  1  SPI slave select; reserved.
- spi_mosi  out  1  SPI data out; reserved.
- uart_rx_inst  in  1  boot-load UART serial input, idle high.
- uart_rx  in  1  application UART input; unused.
- uart_tx  out  1  UART transmit; echoes boot bytes.
- uart_txen  out  1  high while uart_tx is transmitting a frame.
- gpio_o  out  20  status bus.

Behaviour:
Reset:
- Reset is asynchronous, active low, on rst_ni.
- In reset: all state clears, uart_tx=1, uart_txen=0, spi_ss=1, spi_mosi=0, gpio_o=0, tempsense_clkout=0.

Synchronisation:
- uart_rx_inst passes through a 2-flop synchroniser. Its reset value is 1.

RX state machine (states IDLE, START, DATA, STOP):
- IDLE: on a falling edge of the synchronised line, go to START.
- START: wait CLKS_PER_BIT/2 cycles, then sample.
  - Sample 0 -> go to DATA.
  - Sample 1 -> glitch; return to IDLE with no output.
- DATA: sample 8 bits, each CLKS_PER_BIT cycles apart, shifting LSB first.
- STOP: after a further CLKS_PER_BIT cycles, sample the stop bit.
  - Stop = 1 -> byte_valid pulses for 1 cycle.
  - Stop = 0 -> framing_err sets (sticky) and the byte is discarded.
  - Either way, return to IDLE.
- Back-to-back frames (next start bit immediately after the stop bit) must be accepted.
- RX is active only while sel=1 and load is not done.

Word assembly:
- A 2-bit byte index places byte k into bits [8k+7:8k].
- On the 4th byte, the assembled word is evaluated on the following cycle.

Word handling:
- Word == 32'h0000_0FFF is the sentinel: load_done sets. It is not stored.
- Any other word: if word_count < IMEM_DEPTH, write imem[word_count] and increment word_count. Otherwise set overflow (sticky) and drop the word.

Memory:
- Synchronous write, 1-cycle write.
- The read port is internal, for downstream core fetch; no external port.

System reset:
- sys_rst_n = rst_ni & (load_done | ~sel).
- If sel is deasserted mid-load, sys_rst_n releases immediately, loading stops and state is kept.
- sel sampled high again does not restart a completed load; only rst_ni does.

Echo transmitter:
- Each valid boot byte is queued in a 1-entry buffer.
- It is transmitted 8N1 at CLKS_PER_BIT; uart_txen=1 from the start bit through the end of the stop bit.
- If a new byte arrives while the buffer is full, the new byte is dropped. This cannot occur at equal baud rates.

gpio_o:
- [15:0] = word_count, saturating at 16 bits.
- [16] = load_done.
- [17] = framing_err.
- [18] = overflow.
- [19] = sys_rst_n.

Other outputs:
- tempsense_clkout = tempsense_clkref & rst_ni (combinational).
- spi_ss held at 1 and spi_mosi held at 0 outside reset.

Test Plan:
- Reset, then sel=1 and line idle -> gpio_o=20'h0, uart_tx=1, uart_txen=0, spi_ss=1.
- Send bytes 13 01 20 00 -> imem[0]=32'h0020_0113, gpio_o[15:0]=1, each byte echoed on uart_tx with uart_txen high for 10 bit times.
- Send 3 words then sentinel bytes FF 0F 00 00 -> gpio_o[15:0]=3, gpio_o[16]=1, gpio_o[19]=1; further bytes are ignored.
- Send a frame with stop bit = 0 -> gpio_o[17]=1 and word_count unchanged. Next valid frames assemble correctly, starting from byte position 0 of a fresh word.
- Use a small IMEM_DEPTH (e.g. 4) and send 5 non-sentinel words -> count=4, gpio_o[18]=1.
- With sel=0 after reset -> gpio_o[19]=1 immediately and UART input is ignored. Assert rst_ni low mid-frame -> all status clears asynchronously.

Source files
------------

// File: rtl/opentitan_soc_top.sv
`default_nettype none
// ---------------------------------------------------------------------------
// opentitan_soc_top : UART boot-loader front end (imem load, sentinel release, echo)
// Rev 1.0
// ---------------------------------------------------------------------------
module opentitan_soc_top #(
  parameter logic [31:0] JTAG_ID      = 32'h0000_0001,
  parameter logic        DirectDmiTap = 1'b1,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned CLKS_PER_BIT = 10417,
  parameter int unsigned IMEM_DEPTH   = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        tempsense_clkref,
  output logic        tempsense_clkout,
  input  logic        sel,
  output logic        spi_ss,
  output logic        spi_mosi,
  input  logic        uart_rx_inst,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        uart_txen,
  output logic [19:0] gpio_o
);
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam int unsigned AW = $clog2(IMEM_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(IMEM_DEPTH);
  localparam logic [DATA_WIDTH-1:0] SENTINEL = DATA_WIDTH'(32'h0000_0FFF);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  logic rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [1:0] byte_idx_q, byte_idx_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic word_rdy_q, word_rdy_d;
  logic [CW-1:0] word_count_q, word_count_d;
  logic load_done_q, load_done_d, framing_err_q, framing_err_d, overflow_q, overflow_d;
  logic tx_buf_full_q, tx_buf_full_d, tx_busy_q, tx_busy_d;
  logic [7:0] tx_buf_q, tx_buf_d;
  logic [9:0] tx_shift_q, tx_shift_d;
  logic [3:0] tx_bit_q, tx_bit_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic rx_en, byte_valid, frame_bad, imem_we, sys_rst_n;
  logic [DATA_WIDTH-1:0] imem [IMEM_DEPTH];
  logic [DATA_WIDTH-1:0] imem_rdata_q;
  logic [15:0] count16;

  assign rx_en = sel & ~load_done_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q     <= 1'b1;
      rx_sync_q     <= 1'b1;
      rx_prev_q     <= 1'b1;
      rx_state_q    <= RX_IDLE;
      rx_cnt_q      <= '0;
      rx_bit_q      <= '0;
      rx_shift_q    <= '0;
      byte_idx_q    <= '0;
      word_q        <= '0;
      word_rdy_q    <= 1'b0;
      word_count_q  <= '0;
      load_done_q   <= 1'b0;
      framing_err_q <= 1'b0;
      overflow_q    <= 1'b0;
      tx_buf_full_q <= 1'b0;
      tx_buf_q      <= '0;
      tx_busy_q     <= 1'b0;
      tx_shift_q    <= '1;
      tx_bit_q      <= '0;
      tx_cnt_q      <= '0;
    end else begin
      rx_meta_q     <= uart_rx_inst;
      rx_sync_q     <= rx_meta_q;
      rx_prev_q     <= rx_sync_q;
      rx_state_q    <= rx_state_d;
      rx_cnt_q      <= rx_cnt_d;
      rx_bit_q      <= rx_bit_d;
      rx_shift_q    <= rx_shift_d;
      byte_idx_q    <= byte_idx_d;
      word_q        <= word_d;
      word_rdy_q    <= word_rdy_d;
      word_count_q  <= word_count_d;
      load_done_q   <= load_done_d;
      framing_err_q <= framing_err_d;
      overflow_q    <= overflow_d;
      tx_buf_full_q <= tx_buf_full_d;
      tx_buf_q      <= tx_buf_d;
      tx_busy_q     <= tx_busy_d;
      tx_shift_q    <= tx_shift_d;
      tx_bit_q      <= tx_bit_d;
      tx_cnt_q      <= tx_cnt_d;
    end
  end

  // Stop bit is sampled mid-bit, so IDLE is re-entered early enough to catch a back-to-back start edge.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    byte_valid = 1'b0;
    frame_bad  = 1'b0;
    if (!rx_en) begin
      rx_state_d = RX_IDLE;
      rx_cnt_d   = '0;
    end else begin
      case (rx_state_q)
        RX_IDLE: begin
          rx_cnt_d = '0;
          if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
        end
        RX_START: begin
          if (rx_cnt_q == HALF_M1) begin
            rx_cnt_d   = '0;
            rx_bit_d   = '0;
            rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_d = rx_cnt_q + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == FULL_M1) begin
            rx_cnt_d   = '0;
            rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
            rx_bit_d   = rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          end else begin
            rx_cnt_d = rx_cnt_q + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (rx_cnt_q == FULL_M1) begin
            rx_cnt_d   = '0;
            rx_state_d = RX_IDLE;
            byte_valid = rx_sync_q;
            frame_bad  = ~rx_sync_q;
          end else begin
            rx_cnt_d = rx_cnt_q + CNT_W'(1);
          end
        end
        default: rx_state_d = RX_IDLE;
      endcase
    end
  end

  always_comb begin
    byte_idx_d    = byte_idx_q;
    word_d        = word_q;
    word_rdy_d    = 1'b0;
    word_count_d  = word_count_q;
    load_done_d   = load_done_q;
    framing_err_d = framing_err_q;
    overflow_d    = overflow_q;
    imem_we       = 1'b0;
    if (frame_bad) begin
      framing_err_d = 1'b1;
      byte_idx_d    = 2'd0;
    end
    if (byte_valid) begin
      word_d[{byte_idx_q, 3'b000} +: 8] = rx_shift_q;
      byte_idx_d = byte_idx_q + 2'd1;
      word_rdy_d = (byte_idx_q == 2'd3);
    end
    if (word_rdy_q) begin
      if (word_q == SENTINEL) begin
        load_done_d = 1'b1;
      end else if (word_count_q < DEPTH_C) begin
        imem_we      = 1'b1;
        word_count_d = word_count_q + CW'(1);
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  always_comb begin
    tx_buf_full_d = tx_buf_full_q;
    tx_buf_d      = tx_buf_q;
    tx_busy_d     = tx_busy_q;
    tx_shift_d    = tx_shift_q;
    tx_bit_d      = tx_bit_q;
    tx_cnt_d      = tx_cnt_q;
    if (tx_busy_q) begin
      if (tx_cnt_q == FULL_M1) begin
        tx_cnt_d   = '0;
        tx_shift_d = {1'b1, tx_shift_q[9:1]};
        if (tx_bit_q == 4'd9) tx_busy_d = 1'b0;
        else tx_bit_d = tx_bit_q + 4'd1;
      end else begin
        tx_cnt_d = tx_cnt_q + CNT_W'(1);
      end
    end else if (tx_buf_full_q) begin
      tx_busy_d     = 1'b1;
      tx_shift_d    = {1'b1, tx_buf_q, 1'b0};
      tx_bit_d      = '0;
      tx_cnt_d      = '0;
      tx_buf_full_d = 1'b0;
    end
    if (byte_valid && !tx_buf_full_q) begin
      tx_buf_full_d = 1'b1;
      tx_buf_d      = rx_shift_q;
    end
  end

  // Read port tracks the most recently written word for the downstream fetch path.
  always_ff @(posedge clk_i) begin
    if (imem_we) imem[word_count_q[AW-1:0]] <= word_q;
    imem_rdata_q <= imem[word_count_q[AW-1:0] - AW'(1)];
  end

  if (CW > 16) begin : g_count_sat
    assign count16 = (|word_count_q[CW-1:16]) ? 16'hFFFF : word_count_q[15:0];
  end else begin : g_count_ext
    assign count16 = 16'(word_count_q);
  end

  assign sys_rst_n        = rst_ni & (load_done_q | ~sel);
  assign gpio_o           = {sys_rst_n, overflow_q, framing_err_q, load_done_q, count16};
  assign uart_tx          = tx_busy_q ? tx_shift_q[0] : 1'b1;
  assign uart_txen        = tx_busy_q;
  assign spi_ss           = 1'b1;
  assign spi_mosi         = 1'b0;
  assign tempsense_clkout = tempsense_clkref & rst_ni;

  logic unused_inputs;
  assign unused_inputs = ^{uart_rx, JTAG_ID, DirectDmiTap, imem_rdata_q};
endmodule
`default_nettype wire

// File: tb/tb_opentitan_soc_top.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_opentitan_soc_top : directed bench with a byte/word-level boot-load model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_opentitan_soc_top;
  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sel = 1'b1;
  logic clkref = 1'b1;
  logic rx_a = 1'b1, rx_b = 1'b1;
  logic tsout_a, tsout_b, spi_ss_a, spi_ss_b, spi_mosi_a, spi_mosi_b;
  logic tx_a, tx_b, txen_a, txen_b;
  logic [19:0] gpio_a, gpio_b;

  always #5 clk = ~clk;

  opentitan_soc_top #(.CLKS_PER_BIT(CPB)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .tempsense_clkref(clkref), .tempsense_clkout(tsout_a),
    .sel(sel), .spi_ss(spi_ss_a), .spi_mosi(spi_mosi_a), .uart_rx_inst(rx_a),
    .uart_rx(1'b1), .uart_tx(tx_a), .uart_txen(txen_a), .gpio_o(gpio_a));

  opentitan_soc_top #(.CLKS_PER_BIT(CPB), .IMEM_DEPTH(4)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .tempsense_clkref(clkref), .tempsense_clkout(tsout_b),
    .sel(sel), .spi_ss(spi_ss_b), .spi_mosi(spi_mosi_b), .uart_rx_inst(rx_b),
    .uart_rx(1'b1), .uart_tx(tx_b), .uart_txen(txen_b), .gpio_o(gpio_b));

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Model: per-DUT load status, byte assembly, stored words (A only), expected echo bytes (A only)
  int          m_cnt [2];
  int          m_idx [2];
  bit          m_done[2], m_ferr[2], m_ovf[2];
  logic [31:0] m_word[2];
  int          m_depth[2] = '{1024, 4};
  logic [31:0] m_mem_a[$];
  logic [7:0]  exp_echo[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_idx[i] = 0; m_done[i] = 0; m_ferr[i] = 0; m_ovf[i] = 0; m_word[i] = '0;
    end
    m_mem_a.delete();
  endfunction

  function automatic void model_frame(input int id, input logic [7:0] b, input bit good);
    if (!(sel && !m_done[id])) return;
    if (!good) begin
      m_ferr[id] = 1; m_idx[id] = 0;
      return;
    end
    if (id == 0) exp_echo.push_back(b);
    m_word[id][8*m_idx[id] +: 8] = b;
    m_idx[id]++;
    if (m_idx[id] == 4) begin
      m_idx[id] = 0;
      if (m_word[id] == 32'h0000_0FFF) m_done[id] = 1;
      else if (m_cnt[id] < m_depth[id]) begin
        m_cnt[id]++;
        if (id == 0) m_mem_a.push_back(m_word[id]);
      end else m_ovf[id] = 1;
    end
  endfunction

  function automatic logic [19:0] exp_gpio(input int id);
    logic [15:0] c;
    c = (m_cnt[id] > 65535) ? 16'hFFFF : 16'(m_cnt[id]);
    return {rst_n & (m_done[id] | ~sel), m_ovf[id], m_ferr[id], m_done[id], c};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("gpio_a", {12'd0, gpio_a}, {12'd0, exp_gpio(0)});
      check("gpio_b", {12'd0, gpio_b}, {12'd0, exp_gpio(1)});
      if (!txen_a) check("tx_idle_a", {31'd0, tx_a}, 32'd1);
      check("spi_a", {30'd0, spi_ss_a, spi_mosi_a}, 32'd2);
    end
  end

  // Decodes every echo frame from DUT A and matches it against the expected byte stream.
  initial begin : echo_mon
    int n;
    logic [9:0] bits;
    forever begin
      @(negedge clk);
      if (txen_a === 1'b1) begin
        n = 0;
        bits = '1;
        while (txen_a === 1'b1 && n < 12*CPB) begin
          if (n % CPB == CPB/2 && n/CPB < 10) bits[n/CPB] = tx_a;
          n++;
          @(negedge clk);
        end
        if (rst_n) begin
          check("echo_len", n, 10*CPB);
          check("echo_start", {31'd0, bits[0]}, 32'd0);
          check("echo_stop", {31'd0, bits[9]}, 32'd1);
          if (exp_echo.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL echo_unexpected: byte %h with none expected", bits[8:1]);
          end else begin
            check("echo_data", {24'd0, bits[8:1]}, {24'd0, exp_echo.pop_front()});
          end
        end
      end
    end
  end

  task automatic drive(input int id, input logic v);
    if (id == 0) rx_a = v; else rx_b = v;
  endtask

  task automatic send_frame(input int id, input logic [7:0] b, input bit good);
    logic [9:0] f;
    f = {good, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      drive(id, f[i]);
      repeat (CPB) @(negedge clk);
    end
    if (!good) begin
      drive(id, 1'b1);
      repeat (CPB) @(negedge clk);
    end
    drive(id, 1'b1);
    model_frame(id, b, good);
  endtask

  task automatic send_word(input int id, input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_frame(id, w[8*i +: 8], 1'b1);
  endtask

  task automatic idle(input int n);
    @(posedge clk) chk_en = 1'b1;
    repeat (n) @(negedge clk);
    @(posedge clk) chk_en = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_gpio", {12'd0, gpio_a}, 32'h0);
    check("rst_tx", {30'd0, tx_a, txen_a}, 32'd2);
    check("rst_spi", {30'd0, spi_ss_a, spi_mosi_a}, 32'd2);
    check("rst_tsout", {31'd0, tsout_a}, 32'd0);
    rst_n = 1'b1;
    idle(20);
    check("tsout_run", {31'd0, tsout_a}, 32'd1);

    // First word, bytes sent back to back
    send_frame(0, 8'h13, 1'b1); send_frame(0, 8'h01, 1'b1);
    send_frame(0, 8'h20, 1'b1); send_frame(0, 8'h00, 1'b1);
    idle(12*CPB);
    check("word0_cnt", {16'd0, gpio_a[15:0]}, 32'd1);
    check("imem0", dut_a.imem[0], 32'h0020_0113);

    // Partial word, then a framing error restarts assembly at byte 0
    send_frame(0, 8'hAA, 1'b1); send_frame(0, 8'hBB, 1'b1);
    send_frame(0, 8'h55, 1'b0);
    idle(12*CPB);
    check("ferr", {12'd0, gpio_a}, 32'h2_0001);
    send_word(0, 32'h0102_0304);
    idle(12*CPB);
    check("imem1", dut_a.imem[1], 32'h0102_0304);

    send_word(0, 32'h4433_2211);
    send_word(0, 32'hDEAD_BEEF);
    send_word(0, 32'h0000_0FFF);
    idle(12*CPB);
    check("done", {12'd0, gpio_a}, 32'hB_0004);
    send_word(0, 32'h0403_0201);
    idle(12*CPB);
    check("after_done", {12'd0, gpio_a}, 32'hB_0004);
    for (int i = 0; i < m_mem_a.size(); i++) check("imem_a", dut_a.imem[i], m_mem_a[i]);

    // Small memory: fifth word overflows
    for (int i = 0; i < 5; i++) send_word(1, 32'h1000_0000 + 32'(i));
    idle(4*CPB);
    check("ovf_b", {12'd0, gpio_b}, 32'h4_0004);
    check("imem_b3", dut_b.imem[3], 32'h1000_0003);

    // Bypass mode releases system reset immediately and ignores UART
    sel = 1'b0;
    #1 check("bypass_b", {31'd0, gpio_b[19]}, 32'd1);
    @(negedge clk);
    send_word(1, 32'h1234_5678);
    idle(4*CPB);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("bypass_a", {12'd0, gpio_a}, 32'h8_0000);
    send_word(0, 32'h0000_0FFF);
    idle(4*CPB);

    // Asynchronous reset in the middle of a frame while an echo is in flight
    sel = 1'b1;
    @(negedge clk);
    send_word(0, 32'hCAFE_F00D);
    rx_a = 1'b0;
    repeat (4*CPB) @(negedge clk);
    check("pre_rst", {12'd0, gpio_a}, 32'h0_0001);
    check("pre_rst_txen", {31'd0, txen_a}, 32'd1);
    #3 rst_n = 1'b0;
    exp_echo.delete();
    model_reset();
    #1;
    check("async_gpio", {12'd0, gpio_a}, 32'h0);
    check("async_tx", {30'd0, tx_a, txen_a}, 32'd2);
    @(negedge clk) rx_a = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(4*CPB);
    send_word(0, 32'h8765_4321);
    idle(12*CPB);
    check("recover", dut_a.imem[0], 32'h8765_4321);

    for (int i = 0; i < 20*CPB && exp_echo.size() != 0; i++) @(negedge clk);
    check("echo_drain", exp_echo.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
